// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl
// Turn sequencer for the tic-tac-toe datapath. Holds the 3x3 board, alternates
// moves between player 1 and player 2, hands the board to an external
// registered win detector and ends the game on its winner code. Also keeps
// saturating per-outcome scores and forfeits a turn after TURN_TIMEOUT cycles.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   new_game     pulse: clear board and start the next game (highest priority)
//   p1_valid/pos player 1 move request, target cell 1..9
//   p2_valid/pos player 2 move request, target cell 1..9
//   winner       win detector result: 00 continue, 01 P1, 10 P2, 11 tie
//   pos1..pos9   board cells: 00 empty, 01 P1, 10 P2
//   turn         01 P1 to move, 10 P2 to move, 00 no move accepted
//   move_ack     pulse, move accepted
//   move_err     pulse, active player's move rejected
//   timeout_evt  pulse, active player forfeited the turn
//   game_over    high while the game is finished
//   result       winner code of the last game, held until new_game
//   p1_score, p2_score, tie_score   saturating game counters
module ttt_game_ctrl #(
  parameter int unsigned TURN_TIMEOUT = 500000000,
  parameter int unsigned SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic               p1_valid,
  input  logic [3:0]         p1_pos,
  input  logic               p2_valid,
  input  logic [3:0]         p2_pos,
  input  logic [1:0]         winner,
  output logic [1:0]         pos1,
  output logic [1:0]         pos2,
  output logic [1:0]         pos3,
  output logic [1:0]         pos4,
  output logic [1:0]         pos5,
  output logic [1:0]         pos6,
  output logic [1:0]         pos7,
  output logic [1:0]         pos8,
  output logic [1:0]         pos9,
  output logic [1:0]         turn,
  output logic               move_ack,
  output logic               move_err,
  output logic               timeout_evt,
  output logic               game_over,
  output logic [1:0]         result,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [SCORE_W-1:0] tie_score
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    P1_TURN  = 3'd1,
    P2_TURN  = 3'd2,
    CHK_WAIT = 3'd3,
    CHK_EVAL = 3'd4,
    OVER     = 3'd5
  } state_t;

  // Counter only needs to reach TURN_TIMEOUT-1.
  localparam int unsigned CNT_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
      (TURN_TIMEOUT > 0) ? CNT_W'(TURN_TIMEOUT - 1) : '0;
  localparam bit TO_EN = (TURN_TIMEOUT != 0);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 start_p2_reg, start_p2_next;
  logic                 mover_p2_reg, mover_p2_next;
  logic                 ack_reg, ack_next;
  logic                 err_reg, err_next;
  logic                 to_reg, to_next;
  logic [1:0]           turn_reg, turn_next;
  logic                 over_reg;
  logic [1:0]           result_reg, result_next;
  logic [SCORE_W-1:0]   p1_score_reg, p1_score_next;
  logic [SCORE_W-1:0]   p2_score_reg, p2_score_next;
  logic [SCORE_W-1:0]   tie_score_reg, tie_score_next;

  logic [1:0]           board [9];
  logic [8:0]           cell_we;
  logic                 board_clr;

  // Active player's request; the idle player's inputs never reach the FSM.
  logic                 act_is_p2;
  logic                 act_valid;
  logic [3:0]           act_pos;
  logic [1:0]           act_code;
  logic [8:0]           act_onehot;
  logic [1:0]           act_cell;
  logic                 act_pos_ok;
  logic                 accept;

  assign act_is_p2 = (state_reg == P2_TURN);
  assign act_valid = act_is_p2 ? p2_valid : p1_valid;
  assign act_pos   = act_is_p2 ? p2_pos   : p1_pos;
  assign act_code  = act_is_p2 ? 2'b10    : 2'b01;

  // Board cells, each with its own clear/write enable.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cell
      logic [1:0] cell_reg;

      assign act_onehot[gi] = (act_pos == 4'(gi + 1));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cell_reg <= 2'b00;
        end else if (board_clr) begin
          cell_reg <= 2'b00;
        end else if (cell_we[gi]) begin
          cell_reg <= act_code;
        end
      end

      assign board[gi] = cell_reg;
    end
  endgenerate

  // Out-of-range positions (0, 10..15) select no cell, so act_pos_ok is low.
  always_comb begin
    act_cell = 2'b00;
    for (int i = 0; i < 9; i++) begin
      if (act_onehot[i]) begin
        act_cell = act_cell | board[i];
      end
    end
  end

  assign act_pos_ok = |act_onehot;
  assign accept     = act_valid && act_pos_ok && (act_cell == 2'b00);

  // Next-state and output logic.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    start_p2_next  = start_p2_reg;
    mover_p2_next  = mover_p2_reg;
    ack_next       = 1'b0;
    err_next       = 1'b0;
    to_next        = 1'b0;
    cell_we        = '0;
    board_clr      = 1'b0;
    result_next    = result_reg;
    p1_score_next  = p1_score_reg;
    p2_score_next  = p2_score_reg;
    tie_score_next = tie_score_reg;

    if (new_game) begin
      board_clr     = 1'b1;
      result_next   = 2'b00;
      cnt_next      = '0;
      state_next    = start_p2_reg ? P2_TURN : P1_TURN;
      start_p2_next = ~start_p2_reg;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = IDLE;
        end

        P1_TURN, P2_TURN: begin
          if (act_valid && !accept) begin
            err_next = 1'b1;
          end
          // An accepted move takes precedence over a forfeit on the same cycle.
          if (accept) begin
            cell_we       = act_onehot;
            ack_next      = 1'b1;
            mover_p2_next = act_is_p2;
            cnt_next      = '0;
            state_next    = CHK_WAIT;
          end else if (TO_EN && (cnt_reg == CNT_LAST)) begin
            to_next    = 1'b1;
            cnt_next   = '0;
            state_next = act_is_p2 ? P1_TURN : P2_TURN;
          end else if (TO_EN) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end

        // Gives the win detector its register stage to see the new board.
        CHK_WAIT: begin
          state_next = CHK_EVAL;
        end

        CHK_EVAL: begin
          if (winner == 2'b00) begin
            cnt_next   = '0;
            state_next = mover_p2_reg ? P1_TURN : P2_TURN;
          end else begin
            result_next = winner;
            state_next  = OVER;
            case (winner)
              2'b01: begin
                if (p1_score_reg != '1) p1_score_next = p1_score_reg + SCORE_W'(1);
              end
              2'b10: begin
                if (p2_score_reg != '1) p2_score_next = p2_score_reg + SCORE_W'(1);
              end
              default: begin
                if (tie_score_reg != '1) tie_score_next = tie_score_reg + SCORE_W'(1);
              end
            endcase
          end
        end

        OVER: begin
          state_next = OVER;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // turn is registered from the next state so it lines up with state_reg.
  always_comb begin
    case (state_next)
      P1_TURN: turn_next = 2'b01;
      P2_TURN: turn_next = 2'b10;
      default: turn_next = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      start_p2_reg  <= 1'b0;
      mover_p2_reg  <= 1'b0;
      ack_reg       <= 1'b0;
      err_reg       <= 1'b0;
      to_reg        <= 1'b0;
      turn_reg      <= 2'b00;
      over_reg      <= 1'b0;
      result_reg    <= 2'b00;
      p1_score_reg  <= '0;
      p2_score_reg  <= '0;
      tie_score_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      start_p2_reg  <= start_p2_next;
      mover_p2_reg  <= mover_p2_next;
      ack_reg       <= ack_next;
      err_reg       <= err_next;
      to_reg        <= to_next;
      turn_reg      <= turn_next;
      over_reg      <= (state_next == OVER);
      result_reg    <= result_next;
      p1_score_reg  <= p1_score_next;
      p2_score_reg  <= p2_score_next;
      tie_score_reg <= tie_score_next;
    end
  end

  assign pos1        = board[0];
  assign pos2        = board[1];
  assign pos3        = board[2];
  assign pos4        = board[3];
  assign pos5        = board[4];
  assign pos6        = board[5];
  assign pos7        = board[6];
  assign pos8        = board[7];
  assign pos9        = board[8];
  assign turn        = turn_reg;
  assign move_ack    = ack_reg;
  assign move_err    = err_reg;
  assign timeout_evt = to_reg;
  assign game_over   = over_reg;
  assign result      = result_reg;
  assign p1_score    = p1_score_reg;
  assign p2_score    = p2_score_reg;
  assign tie_score   = tie_score_reg;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed testbench for ttt_game_ctrl with a registered win detector model.
module tb_ttt_game_ctrl;

  localparam int unsigned TURN_TIMEOUT = 8;
  localparam int unsigned SCORE_W      = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               new_game;
  logic               p1_valid;
  logic [3:0]         p1_pos;
  logic               p2_valid;
  logic [3:0]         p2_pos;
  logic [1:0]         winner = 2'b00;
  logic [1:0]         pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic [1:0]         turn;
  logic               move_ack, move_err, timeout_evt, game_over;
  logic [1:0]         result;
  logic [SCORE_W-1:0] p1_score, p2_score, tie_score;

  logic [1:0]         brd [9];

  int n_vec = 0;
  int n_err = 0;

  ttt_game_ctrl #(
    .TURN_TIMEOUT(TURN_TIMEOUT),
    .SCORE_W     (SCORE_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .new_game   (new_game),
    .p1_valid   (p1_valid),
    .p1_pos     (p1_pos),
    .p2_valid   (p2_valid),
    .p2_pos     (p2_pos),
    .winner     (winner),
    .pos1       (pos1),
    .pos2       (pos2),
    .pos3       (pos3),
    .pos4       (pos4),
    .pos5       (pos5),
    .pos6       (pos6),
    .pos7       (pos7),
    .pos8       (pos8),
    .pos9       (pos9),
    .turn       (turn),
    .move_ack   (move_ack),
    .move_err   (move_err),
    .timeout_evt(timeout_evt),
    .game_over  (game_over),
    .result     (result),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .tie_score  (tie_score)
  );

  always #5 clk = ~clk;

  always_comb begin
    brd[0] = pos1; brd[1] = pos2; brd[2] = pos3;
    brd[3] = pos4; brd[4] = pos5; brd[5] = pos6;
    brd[6] = pos7; brd[7] = pos8; brd[8] = pos9;
  end

  // Environment: registered win detector (one cycle of latency).
  function automatic logic [1:0] win_of(input logic [1:0] b [9]);
    int ln [8][3];
    logic full;
    ln = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
           '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    for (int k = 0; k < 8; k++) begin
      if (b[ln[k][0]] != 2'b00 && b[ln[k][0]] == b[ln[k][1]] &&
          b[ln[k][0]] == b[ln[k][2]]) begin
        return b[ln[k][0]];
      end
    end
    full = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (b[k] == 2'b00) full = 1'b0;
    end
    return full ? 2'b11 : 2'b00;
  endfunction

  always @(posedge clk) winner <= win_of(brd);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    $display("new_game turn=%0d", turn);
  endtask

  task automatic move(input int p, input int pos);
    if (p == 1) begin p1_valid = 1'b1; p1_pos = 4'(pos); end
    else        begin p2_valid = 1'b1; p2_pos = 4'(pos); end
    tick();
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    $display("move p%0d pos %0d ack=%0b err=%0b", p, pos, move_ack, move_err);
  endtask

  // Accepted move, then two cycles of evaluation; next_turn 0 means game ends.
  task automatic play(input int p, input int pos, input logic [1:0] next_turn);
    move(p, pos);
    check("play_ack", move_ack, 1);
    check("play_cell", brd[pos-1], p);
    check("play_turn_wait", turn, 0);
    tick();
    check("play_turn_eval", turn, 0);
    tick();
    check("play_next_turn", turn, next_turn);
  endtask

  initial begin
    int bad [3];
    bad = '{5, 0, 12};
    reset    = 1'b0;
    new_game = 1'b0;
    p1_valid = 1'b0;
    p1_pos   = 4'd0;
    p2_valid = 1'b0;
    p2_pos   = 4'd0;
    repeat (3) tick();

    // Reset state
    check("rst_turn", turn, 0);
    check("rst_over", game_over, 0);
    check("rst_result", result, 0);
    check("rst_p1", p1_score, 0);
    check("rst_tie", tie_score, 0);
    check("rst_ack", move_ack, 0);
    check("rst_pos5", pos5, 0);
    reset = 1'b1;
    tick();
    check("idle_turn", turn, 0);

    // Game 1: P1 starts
    pulse_new_game();
    check("g1_turn", turn, 1);
    move(1, 5);
    check("m1_pos5", pos5, 1);
    check("m1_ack", move_ack, 1);
    check("m1_turn0", turn, 0);
    tick();
    check("m1_ack_low", move_ack, 0);
    check("m1_turn1", turn, 0);
    tick();
    check("m1_turn2", turn, 2);

    // Rejected P2 moves
    foreach (bad[i]) begin
      move(2, bad[i]);
      check("bad_err", move_err, 1);
      check("bad_ack", move_ack, 0);
      check("bad_turn", turn, 2);
      check("bad_pos5", pos5, 1);
    end
    // Inactive player's request ignored
    move(1, 1);
    check("idle_p_ack", move_ack, 0);
    check("idle_p_err", move_err, 0);
    check("idle_p_pos1", pos1, 0);
    check("idle_p_turn", turn, 2);

    play(2, 4, 1);
    play(1, 1, 2);
    play(2, 2, 1);
    play(1, 9, 0);
    check("g1_over", game_over, 1);
    check("g1_result", result, 1);
    check("g1_p1", p1_score, 1);
    check("g1_p2", p2_score, 0);
    // Moves ignored in OVER
    p1_valid = 1'b1; p1_pos = 4'd3;
    p2_valid = 1'b1; p2_pos = 4'd3;
    tick();
    p1_valid = 1'b0; p2_valid = 1'b0;
    check("over_ack", move_ack, 0);
    check("over_err", move_err, 0);
    check("over_pos3", pos3, 0);
    check("over_hold", game_over, 1);

    // Game 2: P2 starts; timeout, then move on the timeout cycle, then draw
    pulse_new_game();
    check("g2_turn", turn, 2);
    check("g2_clr", pos5, 0);
    check("g2_over", game_over, 0);
    check("g2_result", result, 0);
    check("g2_p1_kept", p1_score, 1);
    repeat (7) tick();
    check("to_early", timeout_evt, 0);
    check("to_early_turn", turn, 2);
    tick();
    check("to_evt", timeout_evt, 1);
    check("to_turn", turn, 1);
    tick();
    check("to_pulse_end", timeout_evt, 0);
    repeat (6) tick();
    move(1, 5);
    check("to_race_ack", move_ack, 1);
    check("to_race_evt", timeout_evt, 0);
    check("to_race_pos5", pos5, 1);
    tick();
    tick();
    check("to_race_turn", turn, 2);
    play(2, 2, 1);
    play(1, 1, 2);
    play(2, 9, 1);
    play(1, 3, 2);
    play(2, 4, 1);
    play(1, 6, 2);
    play(2, 7, 1);
    play(1, 8, 0);
    check("g2_result_tie", result, 3);
    check("g2_tie", tie_score, 1);
    check("g2_over_set", game_over, 1);

    // Game 3: P1 starts, P1 wins
    pulse_new_game();
    check("g3_turn", turn, 1);
    play(1, 1, 2); play(2, 4, 1); play(1, 2, 2); play(2, 5, 1); play(1, 3, 0);
    check("g3_p1", p1_score, 2);

    // Game 4: P2 starts, P1 wins
    pulse_new_game();
    check("g4_turn", turn, 2);
    play(2, 4, 1); play(1, 1, 2); play(2, 5, 1); play(1, 2, 2); play(2, 9, 1); play(1, 3, 0);
    check("g4_result", result, 1);
    check("g4_p1", p1_score, 3);

    // Game 5: P1 wins again, score saturates
    pulse_new_game();
    check("g5_turn", turn, 1);
    play(1, 1, 2); play(2, 4, 1); play(1, 2, 2); play(2, 5, 1); play(1, 3, 0);
    check("g5_result", result, 1);
    check("g5_p1_sat", p1_score, 3);

    // new_game in mid-game keeps scores
    pulse_new_game();
    check("g6_turn", turn, 2);
    play(2, 1, 1);
    pulse_new_game();
    check("g7_clr", pos1, 0);
    check("g7_turn", turn, 1);
    check("g7_p1_kept", p1_score, 3);
    check("g7_tie_kept", tie_score, 1);
    check("g7_over", game_over, 0);

    // Reset during CHK_WAIT
    move(1, 5);
    check("g7_ack", move_ack, 1);
    reset = 1'b0;
    #1;
    check("arst_pos5", pos5, 0);
    check("arst_turn", turn, 0);
    check("arst_p1", p1_score, 0);
    check("arst_tie", tie_score, 0);
    check("arst_ack", move_ack, 0);
    tick();
    reset = 1'b1;
    tick();
    pulse_new_game();
    check("post_rst_turn", turn, 1);
    play(1, 2, 2);
    pulse_new_game();
    check("post_rst_alt", turn, 2);
    check("post_rst_clr", pos2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
